// File: rtl/param_load_sequencer.sv
// param_load_sequencer: power-up sequencer for one-shot parameter loaders.
// Starts loaders one at a time, skips ones already done, watchdogs each wait.
module param_load_sequencer #(
  parameter int NUM_LOADERS    = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13,
  parameter int IDX_W          = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_LOADERS-1:0] loader_done,
  output logic [NUM_LOADERS-1:0] loader_start,
  output logic [IDX_W-1:0]       cur_idx,
  output logic                   busy,
  output logic                   all_done,
  output logic                   error,
  output logic [IDX_W-1:0]       err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_LOADERS - 1);
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic [IDX_W-1:0]       idx_d;
  logic [IDX_W-1:0]       err_idx_d;
  logic [IDX_W-1:0]       idx_inc;
  logic [CNT_W-1:0]       wdog_q;
  logic [CNT_W-1:0]       wdog_d;
  logic [NUM_LOADERS-1:0] pulse_d;
  logic                   advance;

  // The pulse is decided when ISSUE is entered, so a loader
  // that is already done never sees a start pulse.
  function automatic logic [NUM_LOADERS-1:0] pulse_for(
    input logic [IDX_W-1:0]       idx,
    input logic [NUM_LOADERS-1:0] done
  );
    logic [NUM_LOADERS-1:0] p;
    p = '0;
    if (!done[idx]) begin
      p = NUM_LOADERS'(1) << idx;
    end
    return p;
  endfunction

  assign idx_inc = cur_idx + IDX_W'(1);

  // Next-state, next index, watchdog and next pulse.
  always_comb begin
    state_d   = state_q;
    idx_d     = cur_idx;
    err_idx_d = err_idx;
    wdog_d    = wdog_q;
    pulse_d   = '0;
    advance   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_ISSUE;
          idx_d     = '0;
          err_idx_d = '0;
          pulse_d   = pulse_for('0, loader_done);
        end
      end
      S_ISSUE: begin
        wdog_d = '0;
        if (loader_start != '0) begin
          state_d = S_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      S_WAIT: begin
        if (loader_done[cur_idx]) begin
          advance = 1'b1;
        end else if (wdog_q == WD_LAST) begin
          state_d   = S_ERROR;
          err_idx_d = cur_idx;
          wdog_d    = wdog_q + CNT_W'(1);
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (advance) begin
      if (cur_idx == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        state_d = S_ISSUE;
        idx_d   = idx_inc;
        pulse_d = pulse_for(idx_inc, loader_done);
      end
    end
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cur_idx      <= '0;
      err_idx      <= '0;
      wdog_q       <= '0;
      loader_start <= '0;
      busy         <= 1'b0;
      all_done     <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_idx      <= idx_d;
      err_idx      <= err_idx_d;
      wdog_q       <= wdog_d;
      loader_start <= pulse_d;
      busy         <= (state_d == S_ISSUE) ||
                      (state_d == S_WAIT);
      all_done     <= (state_d == S_DONE);
      error        <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_param_load_sequencer.sv
// tb_param_load_sequencer: scoreboard bench for the loader sequencer.
// A sequence model predicts pulse/done/error events with their periods.
module tb_param_load_sequencer;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int CW = 5;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  loader_done = '0;
  logic [N-1:0]  loader_start;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] err_idx;
  logic          busy;
  logic          all_done;
  logic          error;

  param_load_sequencer #(
    .NUM_LOADERS(N),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .loader_done(loader_done),
    .loader_start(loader_start),
    .cur_idx(cur_idx),
    .busy(busy),
    .all_done(all_done),
    .error(error),
    .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  // period index: value seen at a negedge names the current cycle
  int t = 0;
  always @(posedge clk) t <= t + 1;

  // kind: 0 = start pulse, 1 = all_done rise, 2 = error rise
  typedef struct {
    int kind;
    int idx;
    int per;
  } ev_t;

  ev_t expq[$];
  int  compared = 0;
  int  mismatched = 0;
  int  dly[N];
  bit  hang[N];
  int  due[N];
  int  exp_final = 0;
  int  exp_err = 0;
  logic pd = 1'b0;
  logic pe = 1'b0;

  function automatic void chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)",
               name, act, exp, t);
    end
  endfunction

  function automatic int idx_of(logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic void take(int kind, int idx);
    ev_t e;
    if (expq.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_event: got kind %0d idx %0d t=%0d, expected none",
               kind, idx, t);
      return;
    end
    e = expq.pop_front();
    chk("ev_kind", kind, e.kind);
    chk("ev_idx", idx, e.idx);
    chk("ev_period", t, e.per);
  endfunction

  // Monitor: turns DUT outputs into events and scores them.
  always @(negedge clk) begin
    chk("start_onehot0", int'($onehot0(loader_start)), 1);
    if (loader_start != '0) begin
      take(0, idx_of(loader_start));
      chk("pulse_cur_idx", int'(cur_idx), idx_of(loader_start));
      chk("pulse_busy", int'(busy), 1);
    end
    if (all_done && !pd) take(1, int'(cur_idx));
    if (error && !pe) begin
      take(2, int'(err_idx));
      chk("err_busy", int'(busy), 0);
    end
    pd = all_done;
    pe = error;
  end

  // Loaders: done rises dly cycles after the pulse, then sticks.
  task automatic loader_step();
    for (int i = 0; i < N; i++) begin
      if (due[i] >= 0 && due[i] == t) loader_done[i] = 1'b1;
      if (loader_start[i]) due[i] = hang[i] ? -1 : t + dly[i];
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    loader_step();
  endtask

  task automatic clear_loaders();
    loader_done = '0;
    for (int i = 0; i < N; i++) due[i] = -1;
  endtask

  // Sequence model: walk loaders in order from the done snapshot.
  task automatic kick();
    logic [N-1:0] d;
    int p;
    bit stopped;
    d = loader_done;
    p = t + 1;
    stopped = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        p = p + 1;
      end else begin
        expq.push_back('{0, i, p});
        if (hang[i] || dly[i] > TO) begin
          expq.push_back('{2, i, p + TO + 1});
          exp_final = 2;
          exp_err = i;
          stopped = 1'b1;
          break;
        end
        p = p + dly[i] + 1;
      end
    end
    if (!stopped) begin
      expq.push_back('{1, N - 1, p});
      exp_final = 1;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_wait(bit noise);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 400) begin
      start = (noise && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
      n++;
    end
    start = 1'b0;
    if (expq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL run_timeout: %0d events outstanding, expected 0",
               expq.size());
      expq.delete();
    end
    repeat (25) cyc();
    chk("final_busy", int'(busy), 0);
    chk("final_all_done", int'(all_done), int'(exp_final == 1));
    chk("final_error", int'(error), int'(exp_final == 2));
    if (exp_final == 2) begin
      chk("final_err_idx", int'(err_idx), exp_err);
      chk("final_cur_idx", int'(cur_idx), exp_err);
    end else begin
      chk("final_cur_idx", int'(cur_idx), N - 1);
    end
  endtask

  task automatic set_all(int d);
    for (int i = 0; i < N; i++) begin
      dly[i] = d;
      hang[i] = 1'b0;
    end
  endtask

  initial begin
    int n;
    clear_loaders();
    set_all(10);
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("rst_loader_start", int'(loader_start), 0);
    chk("rst_cur_idx", int'(cur_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_all_done", int'(all_done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_idx", int'(err_idx), 0);
    repeat (3) cyc();
    chk("idle_no_start_busy", int'(busy), 0);

    // plain sequence, done 10 cycles after each pulse
    kick();
    run_wait(1'b0);

    // restart with every loader done: all skipped
    kick();
    run_wait(1'b0);

    // loader 1 done from the outset is skipped
    clear_loaders();
    loader_done[1] = 1'b1;
    set_all(10);
    kick();
    run_wait(1'b0);

    // loader 2 hangs; start noise while busy
    clear_loaders();
    set_all(5);
    hang[2] = 1'b1;
    kick();
    run_wait(1'b1);

    // restart from ERROR: 0 and 1 skipped, 2 now completes
    hang[2] = 1'b0;
    dly[2] = 3;
    kick();
    run_wait(1'b1);

    // done on the last watchdog cycle wins
    clear_loaders();
    set_all(3);
    dly[1] = TO;
    kick();
    run_wait(1'b0);

    // one cycle later is a timeout
    clear_loaders();
    set_all(3);
    dly[1] = TO + 1;
    kick();
    run_wait(1'b0);

    // reset while waiting on loader 1
    clear_loaders();
    set_all(3);
    dly[1] = 15;
    kick();
    n = 0;
    while (!loader_start[1] && n < 100) begin
      cyc();
      n++;
    end
    chk("saw_pulse1", int'(loader_start[1]), 1);
    repeat (3) cyc();
    chk("wait1_busy", int'(busy), 1);
    expq.delete();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    clear_loaders();
    chk("mid_rst_loader_start", int'(loader_start), 0);
    chk("mid_rst_cur_idx", int'(cur_idx), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_all_done", int'(all_done), 0);
    chk("mid_rst_error", int'(error), 0);
    chk("mid_rst_err_idx", int'(err_idx), 0);
    kick();
    run_wait(1'b0);

    // randomized runs
    repeat (30) begin
      if ($urandom_range(0, 1) == 1) clear_loaders();
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) loader_done[i] = 1'b1;
        dly[i] = $urandom_range(1, 20);
        hang[i] = ($urandom_range(0, 9) == 0);
      end
      kick();
      run_wait(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
